out_slice_read_sched: RTL
=========================

// Module: out_slice_read_sched
// PURPOSE
// Read-side scheduler for the per-slice output sync buffers, in the clk_rd domain. Drains
// NUM_SLICES buffers in raster order: per line, slice 0 words, then slice 1, ... and so on.
// Absorbs the buffers' 2-cycle read latency with a credit-checked skid FIFO.
// Emits one raster word stream with sof/sol/eol markers and a valid/ready handshake.
// PARAMETERS
// NUM_SLICES      2          number of slice buffers sharing the output port
// DATA_WIDTH      168        word width (4 pixels x 3 comp x 14 b)
// MAX_SLICE_WIDTH 2560       max slice width in pixels
// MAX_SLICE_HEIGHT 2560      max slice height in lines
// RD_LATENCY      2          buf_rd_en -> buf_valid latency in cycles
// SKID_DEPTH      4          skid FIFO entries; must be >= RD_LATENCY+1
// PORTS
// clk             in   1                  read clock (clk_rd domain)
// rst             in   1                  synchronous, active-high reset
// enable          in   1                  start scheduling; sampled only in IDLE
// slices_per_line in   clog2(NUM_SLICES+1) active slices per line, 1..NUM_SLICES
// slice_width     in   clog2(MAX_SLICE_WIDTH) pixels per slice; multiple of 4
// slice_height    in   clog2(MAX_SLICE_HEIGHT+1) lines per slice
// buf_empty       in   NUM_SLICES         per-buffer empty
// buf_sof         in   NUM_SLICES         per-buffer out_sof (level)
// buf_rd_en       out  NUM_SLICES         per-buffer read request; one-hot or zero
// buf_valid       in   NUM_SLICES         per-buffer out_valid
// buf_data        in   NUM_SLICES*DATA_WIDTH  per-buffer out_data; slice s at [s*DW +: DW]
// out_data        out  DATA_WIDTH         raster word
// out_valid       out  1                  word valid
// out_ready       in   1                  downstream accepts when out_valid & out_ready
// out_sof/out_sol/out_eol out 1 each      first word of frame / of line / last word of line
// frame_done      out  1                  1-cycle pulse after the last word of a frame is accepted
// err             out  1                  sticky protocol error; cleared by rst only
// BEHAVIOUR
// - Reset: all outputs 0, FIFO empty, counters 0, state IDLE, credits = SKID_DEPTH.
// - W = slice_width>>2 words per slice-line; S = slices_per_line; H = slice_height.
// - FSM states:
//   IDLE -> ARM when enable=1.
//   ARM: per-slice sticky flag set when buf_sof[s]=1, for s<S.
//        ARM -> READ once all S flags are set and buf_sof[S-1:0] == 0.
//   READ: counters word (0..W-1), slice (0..S-1), line (0..H-1).
//     Word wraps -> slice increments. Slice wraps -> line increments.
//     Line wraps after line H-1 -> DRAIN.
//   DRAIN -> DONE when outstanding = 0 and the FIFO is empty.
//   DONE: pulse frame_done for 1 cycle, then -> IDLE.
// - Issue rule (READ only): buf_rd_en[slice] = ~buf_empty[slice] & (credits != 0).
//   At most 1 issue per cycle. Counters advance only on issue.
// - Credits: decrement on issue, increment on each FIFO pop (out_valid & out_ready).
//   Same-cycle issue and pop leaves credits unchanged. The FIFO therefore never overflows.
// - Each issue pushes a tag through a RD_LATENCY-deep shift register: {slice, sof, sol, eol}.
//   sof = first word of the frame; sol = word 0 of slice 0; eol = word W-1 of slice S-1.
//   When buf_valid[tag.slice]=1, {buf_data[tag.slice], markers} is pushed into the FIFO.
// - Output: FIFO head drives out_*. Registered output; min latency rd_en -> out_valid = RD_LATENCY+1.
//   Data and markers hold stable while out_valid & ~out_ready.
// - err is set if any of these occurs:
//   buf_valid on a slice other than the tag's slice;
//   buf_valid with no tag pending;
//   a tag is due with no buf_valid;
//   buf_sof[s] rises in READ for s<S.
//   Operation continues after err. A buf_sof error does not abort the frame.
// - S=1 degenerates to a single-buffer drain. W=1 sets sol=eol on every word.
// - rst mid-frame: immediate return to the reset state. In-flight tags and FIFO contents are discarded.
// TESTING
// - S=2, W=4, H=2, buffers always full, out_ready=1 -> 16 words: slice order 0,0,0,0,1,1,1,1, repeated.
//   sof on word 0; sol on words 0 and 8; eol on words 7 and 15; frame_done 1 cycle after word 15.
// - out_ready=0 for 10 cycles mid-line -> issues stop after 4 outstanding.
//   No word lost or duplicated; out_data stable while stalled.
// - buf_empty[1]=1 for 20 cycles at a slice boundary -> no buf_rd_en[0] issued ahead;
//   stream resumes in order with slice 1 word 0.
// - Inject buf_valid[0] while the tag says slice 1 -> err=1 and stays 1; frame still completes.
// - rst pulsed at word 5 of line 1 -> outputs 0 the next cycle.
//   Re-enable, then a full 16-word frame completes correctly.
// - S=1, W=1, H=3 -> 3 words, each with sol=eol=1; sof only on the first.

Source files
------------

// File: rtl/out_slice_read_sched.sv
// Drains NUM_SLICES output sync buffers in raster order into one marked word stream.
// rd_en -> out_valid min RD_LATENCY+1 cycles; credits stop reads once SKID_DEPTH words are owed.
module out_slice_read_sched #(
  parameter int NUM_SLICES       = 2,
  parameter int DATA_WIDTH       = 168,
  parameter int MAX_SLICE_WIDTH  = 2560,
  parameter int MAX_SLICE_HEIGHT = 2560,
  parameter int RD_LATENCY       = 2,
  parameter int SKID_DEPTH       = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  enable,
  input  logic [$clog2(NUM_SLICES+1)-1:0]       slices_per_line,
  input  logic [$clog2(MAX_SLICE_WIDTH)-1:0]    slice_width,
  input  logic [$clog2(MAX_SLICE_HEIGHT+1)-1:0] slice_height,
  input  logic [NUM_SLICES-1:0]                 buf_empty,
  input  logic [NUM_SLICES-1:0]                 buf_sof,
  output logic [NUM_SLICES-1:0]                 buf_rd_en,
  input  logic [NUM_SLICES-1:0]                 buf_valid,
  input  logic [NUM_SLICES*DATA_WIDTH-1:0]      buf_data,
  output logic [DATA_WIDTH-1:0]                 out_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic                                  out_sof,
  output logic                                  out_sol,
  output logic                                  out_eol,
  output logic                                  frame_done,
  output logic                                  err
);

  localparam int SW = $clog2(NUM_SLICES+1);
  localparam int XW = $clog2(MAX_SLICE_WIDTH);
  localparam int YW = $clog2(MAX_SLICE_HEIGHT+1);
  localparam int CW = $clog2(SKID_DEPTH+1);
  localparam int PW = $clog2(SKID_DEPTH);
  localparam int FW = DATA_WIDTH + 3;

  typedef enum logic [2:0] {IDLE, ARM, READ, DRAIN, DONE} state_t;

  state_t                state;
  logic [NUM_SLICES-1:0] sof_seen, sof_q, act_mask, sof_rise;
  logic [XW-1:0]         word_cnt, words_m1;
  logic [SW-1:0]         slice_cnt;
  logic [YW-1:0]         line_cnt;
  logic                  last_word, last_slice, last_line;
  logic [CW-1:0]         credits;
  logic                  cur_empty, issue;

  // Tag pipeline mirrors the buffer read latency; markers are {sof, sol, eol}.
  logic [RD_LATENCY-1:0] tag_vld;
  logic [SW-1:0]         tag_slice [RD_LATENCY];
  logic [2:0]            tag_mk    [RD_LATENCY];
  logic [2:0]            new_mk;
  logic                  due, due_valid, stray, push, drop, pop;
  logic [SW-1:0]         due_slice;
  logic [DATA_WIDTH-1:0] due_data;

  logic [FW-1:0]         mem [SKID_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         cnt;
  logic [FW-1:0]         head;

  always_comb begin
    act_mask = '0;
    for (int s = 0; s < NUM_SLICES; s++) act_mask[s] = (SW'(s) < slices_per_line);
    words_m1   = (slice_width >> 2) - XW'(1);
    last_word  = (word_cnt == words_m1);
    last_slice = (slice_cnt == slices_per_line - SW'(1));
    last_line  = (line_cnt == slice_height - YW'(1));
    new_mk     = {(word_cnt == '0) && (slice_cnt == '0) && (line_cnt == '0),
                  (word_cnt == '0) && (slice_cnt == '0),
                  last_word && last_slice};
    cur_empty = 1'b1;
    for (int s = 0; s < NUM_SLICES; s++)
      if (slice_cnt == SW'(s)) cur_empty = buf_empty[s];
    issue = (state == READ) && !cur_empty && (credits != '0);
    buf_rd_en = '0;
    for (int s = 0; s < NUM_SLICES; s++) buf_rd_en[s] = issue && (slice_cnt == SW'(s));

    due       = tag_vld[RD_LATENCY-1];
    due_slice = tag_slice[RD_LATENCY-1];
    due_valid = 1'b0;
    stray     = 1'b0;
    due_data  = '0;
    for (int s = 0; s < NUM_SLICES; s++) begin
      if (due && (due_slice == SW'(s))) begin
        due_valid = buf_valid[s];
        due_data  = buf_data[s*DATA_WIDTH +: DATA_WIDTH];
      end else if (buf_valid[s]) begin
        stray = 1'b1;
      end
    end
    push     = due && due_valid;
    drop     = due && !due_valid;
    pop      = out_valid && out_ready;
    sof_rise = buf_sof & ~sof_q & act_mask;
  end

  assign head      = mem[rd_ptr];
  assign out_valid = (cnt != '0);
  assign out_data  = out_valid ? head[FW-1:3] : '0;
  assign out_sof   = out_valid & head[2];
  assign out_sol   = out_valid & head[1];
  assign out_eol   = out_valid & head[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sof_seen   <= '0;
      sof_q      <= '0;
      word_cnt   <= '0;
      slice_cnt  <= '0;
      line_cnt   <= '0;
      credits    <= CW'(SKID_DEPTH);
      tag_vld    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      sof_q      <= buf_sof;
      frame_done <= 1'b0;
      for (int i = RD_LATENCY-1; i > 0; i--) begin
        tag_vld[i]   <= tag_vld[i-1];
        tag_slice[i] <= tag_slice[i-1];
        tag_mk[i]    <= tag_mk[i-1];
      end
      tag_vld[0]   <= issue;
      tag_slice[0] <= slice_cnt;
      tag_mk[0]    <= new_mk;
      // A tag that never got its data frees its slot too, so a glitch cannot starve reads.
      credits <= credits - CW'(issue) + CW'(pop) + CW'(drop);
      if (push) begin
        mem[wr_ptr] <= {due_data, tag_mk[RD_LATENCY-1]};
        wr_ptr      <= (wr_ptr == PW'(SKID_DEPTH-1)) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= (rd_ptr == PW'(SKID_DEPTH-1)) ? '0 : rd_ptr + PW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
      if (stray || drop || ((state == READ) && (sof_rise != '0))) err <= 1'b1;

      case (state)
        IDLE: if (enable) begin
          state    <= ARM;
          sof_seen <= '0;
        end
        ARM: begin
          sof_seen <= sof_seen | (buf_sof & act_mask);
          if (((sof_seen & act_mask) == act_mask) && ((buf_sof & act_mask) == '0)) begin
            state     <= READ;
            word_cnt  <= '0;
            slice_cnt <= '0;
            line_cnt  <= '0;
          end
        end
        READ: if (issue) begin
          if (last_word) begin
            word_cnt <= '0;
            if (last_slice) begin
              slice_cnt <= '0;
              if (last_line) begin
                line_cnt <= '0;
                state    <= DRAIN;
              end else begin
                line_cnt <= line_cnt + YW'(1);
              end
            end else begin
              slice_cnt <= slice_cnt + SW'(1);
            end
          end else begin
            word_cnt <= word_cnt + XW'(1);
          end
        end
        // Leave as the final word is accepted so frame_done trails it by one cycle.
        DRAIN: if ((tag_vld == '0) && ((cnt == '0) || ((cnt == CW'(1)) && pop))) begin
          state      <= DONE;
          frame_done <= 1'b1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
